// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction-memory handshake plus the IF/ID view
// seen by decode (stall, redirect, instruction outputs).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output opcode,
        output pc_out,
        output pc_plus4
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  opcode,
        input  pc_out,
        input  pc_plus4
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ready handshake, IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds saturating wait/flush counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]   perf_wait_cycles,
    output logic [15:0]   perf_flush_count
`endif
);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pending_pc;
    logic [31:0] w_pending_nxt;
    logic        r_instr_valid;
    logic        w_instr_valid_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_pc_out;
    logic [31:0] w_pc_out_nxt;
    logic [31:0] r_pc_plus4;
    logic [31:0] w_pc_plus4_nxt;

    logic        w_req;
    logic        w_xfer;
    logic        w_consume;
    logic        w_outstanding;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_target      = {bus.redirect_pc[31:2], 2'b00};
    assign w_pc_inc      = r_pc + 32'd4;
    assign w_xfer        = w_req && bus.imem_ready;
    assign w_consume     = r_instr_valid && !bus.stall;
    assign w_outstanding = w_req && !bus.imem_ready;

    // Request only when IF/ID is empty or drains this cycle.
    always_comb begin
        w_req = 1'b0;
        unique case (r_state)
            S_BOOT:    w_req = 1'b0;
            S_FETCH:   w_req = !r_instr_valid || !bus.stall;
            S_DISCARD: w_req = 1'b1;
            default:   w_req = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pending_nxt     = r_pending_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_nxt       = r_instr;
        w_pc_out_nxt      = r_pc_out;
        w_pc_plus4_nxt    = r_pc_plus4;
        unique case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
                if (bus.redirect_valid) begin
                    w_pc_nxt = w_target;
                end
            end
            S_FETCH: begin
                if (bus.redirect_valid) begin
                    w_instr_valid_nxt = 1'b0;
                    w_instr_nxt       = NOP_INSTR;
                    if (w_outstanding) begin
                        // Address must stay put until the old request completes.
                        w_pending_nxt = w_target;
                        w_state_nxt   = S_DISCARD;
                    end else begin
                        w_pc_nxt = w_target;
                    end
                end else if (w_xfer) begin
                    w_instr_valid_nxt = 1'b1;
                    w_instr_nxt       = bus.imem_rdata;
                    w_pc_out_nxt      = r_pc;
                    w_pc_plus4_nxt    = w_pc_inc;
                    w_pc_nxt          = w_pc_inc;
                end else if (w_consume) begin
                    w_instr_valid_nxt = 1'b0;
                    w_instr_nxt       = NOP_INSTR;
                end
            end
            S_DISCARD: begin
                if (bus.redirect_valid) begin
                    w_pending_nxt = w_target;
                end
                if (bus.imem_ready) begin
                    w_pc_nxt    = bus.redirect_valid ? w_target
                                                     : r_pending_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_pending_pc  <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_pc_out      <= 32'd0;
            r_pc_plus4    <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pending_pc  <= w_pending_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_pc_out      <= w_pc_out_nxt;
            r_pc_plus4    <= w_pc_plus4_nxt;
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.opcode      = r_instr[31:26];
    assign bus.pc_out      = r_pc_out;
    assign bus.pc_plus4    = r_pc_plus4;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_wait_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_outstanding && (r_wait_cnt != 16'hFFFF)) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (bus.redirect_valid && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign perf_wait_cycles = r_wait_cnt;
    assign perf_flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
    localparam logic [31:0] RPC = 32'h0000_0040;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    fetch_stage_if bus ();
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_wait_cycles;
    logic [15:0] perf_flush_count;
`endif

    fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_wait_cycles (perf_wait_cycles),
        .perf_flush_count (perf_flush_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: IF/ID as an optional entry, PC, and a pending-redirect mode.
    bit          m_known = 0;
    bit          m_boot;
    bit          m_disc;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    logic [31:0] m_pcp4;
    int          m_wait;
    int          m_flush;

    bit          ovr_en = 0;
    logic [31:0] ovr_val;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_req(input bit stall);
        if (m_boot) return 1'b0;
        if (m_disc) return 1'b1;
        return !m_valid || !stall;
    endfunction

    task automatic model_edge(input bit r, input bit rdy, input bit stl,
                              input bit rv, input logic [31:0] rpc,
                              input logic [31:0] rdata);
        bit          req;
        logic [31:0] tgt;
        if (r) begin
            m_known = 1; m_boot = 1; m_disc = 0;
            m_pc = RPC; m_pend = RPC;
            m_valid = 0; m_instr = NOP; m_pcout = 0; m_pcp4 = 0;
            m_wait = 0; m_flush = 0;
            return;
        end
        req = model_req(stl);
        tgt = rpc & 32'hFFFF_FFFC;
        if (req && !rdy && m_wait < 65535) m_wait++;
        if (rv && m_flush < 65535) m_flush++;
        if (m_boot) begin
            m_boot = 0;
            if (rv) m_pc = tgt;
        end else if (m_disc) begin
            if (rv) m_pend = tgt;
            if (rdy) begin
                m_disc = 0;
                m_pc = m_pend;
            end
        end else if (rv) begin
            m_valid = 0;
            m_instr = NOP;
            if (req && !rdy) begin
                m_disc = 1;
                m_pend = tgt;
            end else begin
                m_pc = tgt;
            end
        end else if (req && rdy) begin
            m_valid = 1;
            m_instr = rdata;
            m_pcout = m_pc;
            m_pcp4  = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
        end else if (m_valid && !stl) begin
            m_valid = 0;
            m_instr = NOP;
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit stl,
                        input bit rv, input logic [31:0] rpc);
        logic [31:0] rd;
        @(negedge clk);
        rst = r;
        bus.imem_ready     = rdy;
        bus.stall          = stl;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        rd = ovr_en ? ovr_val : mem_word(bus.imem_addr);
        bus.imem_rdata = rd;
        #1;
        if (m_known) begin
            chk("imem_req", {31'd0, bus.imem_req}, {31'd0, model_req(stl)});
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
            chk("instr", bus.instr, m_instr);
            chk("opcode", {26'd0, bus.opcode}, {26'd0, m_instr[31:26]});
            chk("pc_out", bus.pc_out, m_pcout);
            chk("pc_plus4", bus.pc_plus4, m_pcp4);
        end
        @(posedge clk);
        #1;
        model_edge(r, rdy, stl, rv, rpc, rd);
    endtask

    initial begin
        bus.imem_ready     = 1'b1;
        bus.imem_rdata     = 32'd0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;

        // Reset, boot bubble, then back-to-back fetches from 0x40.
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_pc_out", bus.pc_out, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h40);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("first_pc_out", bus.pc_out, 32'h40);
        chk("first_pc_plus4", bus.pc_plus4, 32'h44);
        step(0, 1, 0, 0, 0);
        chk("second_pc_out", bus.pc_out, 32'h44);

        // lw at 0x48 then three stall cycles.
        ovr_en = 1; ovr_val = 32'h8C08_0004;
        step(0, 1, 0, 0, 0);
        ovr_en = 0;
        chk("lw_opcode", {26'd0, bus.opcode}, 32'h23);
        chk("lw_valid", {31'd0, bus.instr_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0);
            chk("stall_instr", bus.instr, 32'h8C08_0004);
            chk("stall_pc_out", bus.pc_out, 32'h48);
            chk("stall_addr", bus.imem_addr, 32'h4C);
        end

        // Redirect together with stall: flush wins.
        step(0, 1, 1, 1, 32'h100);
        chk("flush_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("flush_opcode", {26'd0, bus.opcode}, 32'd0);

        // Memory not ready for 4 cycles at 0x100.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            chk("wait_addr", bus.imem_addr, 32'h100);
        end
        step(0, 1, 0, 0, 0);
        chk("wait_done_pc_out", bus.pc_out, 32'h100);
        chk("wait_done_addr", bus.imem_addr, 32'h104);

        // Redirect to 0x203 while a request to 0x10 is outstanding.
        step(0, 1, 0, 1, 32'h0C);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 32'h203);
        chk("disc_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("disc_instr", bus.instr, NOP);
        chk("disc_addr", bus.imem_addr, 32'h10);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("disc_drop_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("disc_new_addr", bus.imem_addr, 32'h200);
        step(0, 1, 0, 0, 0);
        chk("disc_new_pc_out", bus.pc_out, 32'h200);

        // PC wrap at the top of the address space.
        step(0, 1, 0, 1, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_pc_plus4", bus.pc_plus4, 32'h0);
        chk("wrap_pc_out", bus.pc_out, 32'hFFFF_FFFC);

        // Random traffic, including resets mid-request.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) == 0),
                 ($urandom_range(9) < 7),
                 ($urandom_range(9) < 3),
                 ($urandom_range(9) == 0),
                 $urandom);
        end

`ifdef FETCH_PERF_CNT_EN
        chk("perf_flush", {16'd0, perf_flush_count}, m_flush[31:0]);
        chk("perf_wait", {16'd0, perf_wait_cycles}, m_wait[31:0]);
        for (int i = 0; i < 70000; i++) begin
            step(0, 0, 0, 0, 0);
        end
        chk("perf_wait_sat", {16'd0, perf_wait_cycles}, 32'hFFFF);
        chk("perf_wait_model", {16'd0, perf_wait_cycles}, m_wait[31:0]);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
